vx_mem_region_switch: RTL and testbench



---
 rtl/vx_mem_region_switch_pkg.sv | 23 ++
 rtl/vx_mem_region_switch_decoder.sv | 39 +++
 rtl/vx_mem_region_switch.sv | 279 +++++++++++++++++++++++++++
 tb/tb_vx_mem_region_switch.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_region_switch_pkg.sv
// Shared types and helpers for the memory region switch.
package vx_mem_region_switch_pkg;

    // Width of every performance counter; counters wrap silently.
    localparam int PERF_CNT_WIDTH = 44;

    // A request is either fresh (remain empty) or part-way through a split.
    typedef enum logic {
        SPLIT_IDLE = 1'b0,
        SPLIT_BUSY = 1'b1
    } split_state_e;

    // Pending counters must hold the value MAX_PENDING itself, hence the extra bit.
    function automatic int pending_cnt_width(input int max_pending);
        return $clog2(max_pending) + 1;
    endfunction

    // Index width for selecting one of n outputs.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_mem_region_switch_decoder.sv
// Per-lane address-to-region decoder: each lane gets a one-hot output select.
// Region r matches when (addr & mask[r]) == base[r]; the lowest matching region
// wins, and a lane matching nothing goes to the last output (global memory).
module vx_mem_region_switch_decoder
    import vx_mem_region_switch_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int NUM_OUTS   = 2,
    parameter logic [(NUM_OUTS-1)*ADDR_WIDTH-1:0] REGION_BASE = '0,
    parameter logic [(NUM_OUTS-1)*ADDR_WIDTH-1:0] REGION_MASK = '0
) (
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]     addr,
    output logic [NUM_LANES-1:0][NUM_OUTS-1:0]  lane_sel
);

    localparam int IDX_W = idx_width(NUM_OUTS);

    logic [NUM_LANES-1:0][IDX_W-1:0] lane_idx;

    // Scan regions from highest to lowest so the lowest matching region is left in lane_idx.
    always_comb begin
        lane_idx = '0;
        lane_sel = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_idx[l] = IDX_W'(NUM_OUTS - 1);
            for (int r = NUM_OUTS - 2; r >= 0; r--) begin
                if ((addr[l*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[r*ADDR_WIDTH +: ADDR_WIDTH])
                        == REGION_BASE[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    lane_idx[l] = IDX_W'(r);
                end
            end
            for (int o = 0; o < NUM_OUTS; o++) begin
                lane_sel[l][o] = (lane_idx[l] == IDX_W'(o));
            end
        end
    end

endmodule

// File: rtl/vx_mem_region_switch.sv
// N-way address-region switch between one LSU memory port and NUM_OUTS
// downstream ports. Multi-region requests are split one region per cycle,
// responses are merged round-robin through a one-entry output register.
// Optional feature macro: MEM_SWITCH_PERF_EN adds request/split/stall counters.
module vx_mem_region_switch
    import vx_mem_region_switch_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int DATA_SIZE   = 4,
    parameter int ADDR_WIDTH  = 30,
    parameter int TAG_WIDTH   = 8,
    parameter int NUM_OUTS    = 2,
    parameter logic [(NUM_OUTS-1)*ADDR_WIDTH-1:0] REGION_BASE = '0,
    parameter logic [(NUM_OUTS-1)*ADDR_WIDTH-1:0] REGION_MASK = '0,
    parameter int MAX_PENDING = 16
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic                              in_req_valid,
    output logic                              in_req_ready,
    input  logic                              in_req_rw,
    input  logic [NUM_LANES-1:0]              in_req_mask,
    input  logic [NUM_LANES*DATA_SIZE-1:0]    in_req_byteen,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]   in_req_addr,
    input  logic [NUM_LANES*DATA_SIZE*8-1:0]  in_req_data,
    input  logic [TAG_WIDTH-1:0]              in_req_tag,

    output logic                              in_rsp_valid,
    input  logic                              in_rsp_ready,
    output logic [NUM_LANES-1:0]              in_rsp_mask,
    output logic [NUM_LANES*DATA_SIZE*8-1:0]  in_rsp_data,
    output logic [TAG_WIDTH-1:0]              in_rsp_tag,

    output logic                              out_req_valid  [NUM_OUTS],
    input  logic                              out_req_ready  [NUM_OUTS],
    output logic                              out_req_rw     [NUM_OUTS],
    output logic [NUM_LANES-1:0]              out_req_mask   [NUM_OUTS],
    output logic [NUM_LANES*DATA_SIZE-1:0]    out_req_byteen [NUM_OUTS],
    output logic [NUM_LANES*ADDR_WIDTH-1:0]   out_req_addr   [NUM_OUTS],
    output logic [NUM_LANES*DATA_SIZE*8-1:0]  out_req_data   [NUM_OUTS],
    output logic [TAG_WIDTH-1:0]              out_req_tag    [NUM_OUTS],

    input  logic                              out_rsp_valid  [NUM_OUTS],
    input  logic [NUM_LANES-1:0]              out_rsp_mask   [NUM_OUTS],
    input  logic [NUM_LANES*DATA_SIZE*8-1:0]  out_rsp_data   [NUM_OUTS],
    input  logic [TAG_WIDTH-1:0]              out_rsp_tag    [NUM_OUTS],
    output logic                              out_rsp_ready  [NUM_OUTS]
`ifdef MEM_SWITCH_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0]         perf_reqs      [NUM_OUTS],
    output logic [PERF_CNT_WIDTH-1:0]         perf_splits,
    output logic [PERF_CNT_WIDTH-1:0]         perf_stalls
`endif
);

    localparam int CNT_W  = pending_cnt_width(MAX_PENDING);
    localparam int PTR_W  = idx_width(NUM_OUTS);
    localparam int DATA_W = NUM_LANES * DATA_SIZE * 8;

    logic [NUM_LANES-1:0][NUM_OUTS-1:0] lane_sel;
    logic [NUM_OUTS-1:0][NUM_LANES-1:0] hit_mask;
    logic [NUM_LANES-1:0]               eff_mask;
    logic [NUM_LANES-1:0]               sel_mask;
    logic [NUM_LANES-1:0]               left_mask;
    logic [PTR_W-1:0]                   target;
    logic                               has_target;
    logic                               sel_full;
    logic                               sel_ready;
    logic                               issue_valid;
    logic                               req_fire;
    split_state_e                       split_state;

    logic [NUM_LANES-1:0]               remain_q, remain_d;
    logic [NUM_OUTS-1:0][CNT_W-1:0]     pending_q, pending_d;
    logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic                               rsp_valid_q, rsp_valid_d;
    logic [NUM_LANES-1:0]               rsp_mask_q, rsp_mask_d;
    logic [DATA_W-1:0]                  rsp_data_q, rsp_data_d;
    logic [TAG_WIDTH-1:0]               rsp_tag_q, rsp_tag_d;

    logic [PTR_W-1:0]                   grant_idx;
    logic                               grant_any;
    logic                               rsp_fire;

    assign split_state = (remain_q != '0) ? SPLIT_BUSY : SPLIT_IDLE;

    vx_mem_region_switch_decoder #(
        .NUM_LANES   (NUM_LANES),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_OUTS    (NUM_OUTS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decoder (
        .addr     (in_req_addr),
        .lane_sel (lane_sel)
    );

    // Present the lowest region still owed lanes; retire those lanes when it is accepted.
    always_comb begin
        eff_mask = (split_state == SPLIT_BUSY) ? remain_q : in_req_mask;
        for (int o = 0; o < NUM_OUTS; o++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                hit_mask[o][l] = eff_mask[l] & lane_sel[l][o];
            end
        end

        has_target = 1'b0;
        target     = '0;
        for (int o = NUM_OUTS - 1; o >= 0; o--) begin
            if (hit_mask[o] != '0) begin
                has_target = 1'b1;
                target     = PTR_W'(o);
            end
        end

        sel_mask  = '0;
        sel_full  = 1'b0;
        sel_ready = 1'b0;
        for (int o = 0; o < NUM_OUTS; o++) begin
            if (target == PTR_W'(o)) begin
                sel_mask  = hit_mask[o];
                sel_full  = (pending_q[o] == CNT_W'(MAX_PENDING));
                sel_ready = out_req_ready[o];
            end
        end

        // A full target stalls the whole request rather than skipping ahead, keeping order.
        issue_valid = in_req_valid && has_target && !sel_full && !reset;
        req_fire    = issue_valid && sel_ready;
        left_mask   = eff_mask & ~sel_mask;

        remain_d     = remain_q;
        in_req_ready = 1'b0;
        if (req_fire) begin
            remain_d     = left_mask;
            in_req_ready = (left_mask == '0);
        end else if (in_req_valid && !has_target && !reset) begin
            // No active lanes: nothing to route, so retire it immediately to avoid a deadlock.
            in_req_ready = 1'b1;
        end

        for (int o = 0; o < NUM_OUTS; o++) begin
            out_req_valid[o]  = issue_valid && (target == PTR_W'(o));
            out_req_rw[o]     = in_req_rw;
            out_req_mask[o]   = hit_mask[o];
            out_req_byteen[o] = in_req_byteen;
            out_req_addr[o]   = in_req_addr;
            out_req_data[o]   = in_req_data;
            out_req_tag[o]    = in_req_tag;
        end
    end

    // Track in-flight sub-requests per output; simultaneous issue and return cancel out.
    always_comb begin
        pending_d = pending_q;
        for (int o = 0; o < NUM_OUTS; o++) begin
            if ((out_req_valid[o] && out_req_ready[o]) && !(out_rsp_valid[o] && out_rsp_ready[o])) begin
                pending_d[o] = pending_q[o] + CNT_W'(1);
            end else if (!(out_req_valid[o] && out_req_ready[o]) && (out_rsp_valid[o] && out_rsp_ready[o])) begin
                pending_d[o] = pending_q[o] - CNT_W'(1);
            end
        end
    end

    // Round-robin pick among returning responses, starting at the pointer, into the output register.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int o = NUM_OUTS - 1; o >= 0; o--) begin
            if (out_rsp_valid[o]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(o);
            end
        end
        for (int o = NUM_OUTS - 1; o >= 0; o--) begin
            if (out_rsp_valid[o] && (PTR_W'(o) >= rr_ptr_q)) begin
                grant_idx = PTR_W'(o);
            end
        end

        rsp_fire = grant_any && (!rsp_valid_q || in_rsp_ready) && !reset;

        rsp_valid_d = rsp_valid_q;
        rsp_mask_d  = rsp_mask_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rr_ptr_d    = rr_ptr_q;
        if (rsp_fire) begin
            rsp_valid_d = 1'b1;
            rr_ptr_d    = (grant_idx == PTR_W'(NUM_OUTS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end else if (in_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        for (int o = 0; o < NUM_OUTS; o++) begin
            out_rsp_ready[o] = rsp_fire && (grant_idx == PTR_W'(o));
            if (rsp_fire && (grant_idx == PTR_W'(o))) begin
                rsp_mask_d = out_rsp_mask[o];
                rsp_data_d = out_rsp_data[o];
                rsp_tag_d  = out_rsp_tag[o];
            end
        end
    end

    assign in_rsp_valid = rsp_valid_q;
    assign in_rsp_mask  = rsp_mask_q;
    assign in_rsp_data  = rsp_data_q;
    assign in_rsp_tag   = rsp_tag_q;

    // State registers; reset abandons any split in progress and all tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            remain_q    <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_mask_q  <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
        end else begin
            remain_q    <= remain_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_mask_q  <= rsp_mask_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

`ifdef MEM_SWITCH_PERF_EN
    logic [NUM_OUTS-1:0][PERF_CNT_WIDTH-1:0] perf_reqs_q, perf_reqs_d;
    logic [PERF_CNT_WIDTH-1:0]               perf_splits_q, perf_splits_d;
    logic [PERF_CNT_WIDTH-1:0]               perf_stalls_q, perf_stalls_d;

    // Count accepted sub-requests, requests that needed splitting, and blocked cycles.
    always_comb begin
        perf_reqs_d   = perf_reqs_q;
        perf_splits_d = perf_splits_q;
        perf_stalls_d = perf_stalls_q;
        for (int o = 0; o < NUM_OUTS; o++) begin
            if (out_req_valid[o] && out_req_ready[o]) begin
                perf_reqs_d[o] = perf_reqs_q[o] + PERF_CNT_WIDTH'(1);
            end
        end
        if (req_fire && (split_state == SPLIT_IDLE) && (left_mask != '0)) begin
            perf_splits_d = perf_splits_q + PERF_CNT_WIDTH'(1);
        end
        if (in_req_valid && has_target && !reset && (sel_full || !sel_ready)) begin
            perf_stalls_d = perf_stalls_q + PERF_CNT_WIDTH'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reqs_q   <= '0;
            perf_splits_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_reqs_q   <= perf_reqs_d;
            perf_splits_q <= perf_splits_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    // Expose the packed counter array on the unpacked port.
    always_comb begin
        for (int o = 0; o < NUM_OUTS; o++) begin
            perf_reqs[o] = perf_reqs_q[o];
        end
    end

    assign perf_splits = perf_splits_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_mem_region_switch.sv
// Self-checking bench for vx_mem_region_switch: two outputs, region 0 is the
// 0x1000 page, MAX_PENDING of 4. Expected sub-requests and responses are
// queued from a bench-side region model and compared as the DUT produces them.
module tb_vx_mem_region_switch;

    localparam int NUM_LANES   = 4;
    localparam int DATA_SIZE   = 4;
    localparam int ADDR_WIDTH  = 30;
    localparam int TAG_WIDTH   = 8;
    localparam int NUM_OUTS    = 2;
    localparam int MAX_PENDING = 4;
    localparam int DATA_W      = NUM_LANES * DATA_SIZE * 8;
    localparam logic [ADDR_WIDTH-1:0] R0_BASE = 30'h0001000;
    localparam logic [ADDR_WIDTH-1:0] R0_MASK = 30'h0FFF000;

    logic                            clk = 1'b0;
    logic                            reset = 1'b1;
    logic                            in_req_valid = 1'b0;
    logic                            in_req_ready;
    logic                            in_req_rw = 1'b0;
    logic [NUM_LANES-1:0]            in_req_mask = '0;
    logic [NUM_LANES*DATA_SIZE-1:0]  in_req_byteen = '1;
    logic [NUM_LANES*ADDR_WIDTH-1:0] in_req_addr = '0;
    logic [DATA_W-1:0]               in_req_data = '0;
    logic [TAG_WIDTH-1:0]            in_req_tag = '0;
    logic                            in_rsp_valid;
    logic                            in_rsp_ready = 1'b1;
    logic [NUM_LANES-1:0]            in_rsp_mask;
    logic [DATA_W-1:0]               in_rsp_data;
    logic [TAG_WIDTH-1:0]            in_rsp_tag;

    logic                            out_req_valid  [NUM_OUTS];
    logic                            out_req_ready  [NUM_OUTS];
    logic                            out_req_rw     [NUM_OUTS];
    logic [NUM_LANES-1:0]            out_req_mask   [NUM_OUTS];
    logic [NUM_LANES*DATA_SIZE-1:0]  out_req_byteen [NUM_OUTS];
    logic [NUM_LANES*ADDR_WIDTH-1:0] out_req_addr   [NUM_OUTS];
    logic [DATA_W-1:0]               out_req_data   [NUM_OUTS];
    logic [TAG_WIDTH-1:0]            out_req_tag    [NUM_OUTS];
    logic                            out_rsp_valid  [NUM_OUTS];
    logic [NUM_LANES-1:0]            out_rsp_mask   [NUM_OUTS];
    logic [DATA_W-1:0]               out_rsp_data   [NUM_OUTS];
    logic [TAG_WIDTH-1:0]            out_rsp_tag    [NUM_OUTS];
    logic                            out_rsp_ready  [NUM_OUTS];
`ifdef MEM_SWITCH_PERF_EN
    logic [43:0]                     perf_reqs [NUM_OUTS];
    logic [43:0]                     perf_splits;
    logic [43:0]                     perf_stalls;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        int                   port;
        logic [NUM_LANES-1:0] mask;
        logic [TAG_WIDTH-1:0] tag;
        logic [DATA_W-1:0]    data;
    } req_exp_t;

    typedef struct {
        logic [NUM_LANES-1:0] mask;
        logic [TAG_WIDTH-1:0] tag;
        logic [DATA_W-1:0]    data;
    } rsp_exp_t;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];
    int       model_rr = 0;

    vx_mem_region_switch #(
        .NUM_LANES   (NUM_LANES),
        .DATA_SIZE   (DATA_SIZE),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .NUM_OUTS    (NUM_OUTS),
        .REGION_BASE (R0_BASE),
        .REGION_MASK (R0_MASK),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_req_valid   (in_req_valid),
        .in_req_ready   (in_req_ready),
        .in_req_rw      (in_req_rw),
        .in_req_mask    (in_req_mask),
        .in_req_byteen  (in_req_byteen),
        .in_req_addr    (in_req_addr),
        .in_req_data    (in_req_data),
        .in_req_tag     (in_req_tag),
        .in_rsp_valid   (in_rsp_valid),
        .in_rsp_ready   (in_rsp_ready),
        .in_rsp_mask    (in_rsp_mask),
        .in_rsp_data    (in_rsp_data),
        .in_rsp_tag     (in_rsp_tag),
        .out_req_valid  (out_req_valid),
        .out_req_ready  (out_req_ready),
        .out_req_rw     (out_req_rw),
        .out_req_mask   (out_req_mask),
        .out_req_byteen (out_req_byteen),
        .out_req_addr   (out_req_addr),
        .out_req_data   (out_req_data),
        .out_req_tag    (out_req_tag),
        .out_rsp_valid  (out_rsp_valid),
        .out_rsp_mask   (out_rsp_mask),
        .out_rsp_data   (out_rsp_data),
        .out_rsp_tag    (out_rsp_tag),
        .out_rsp_ready  (out_rsp_ready)
`ifdef MEM_SWITCH_PERF_EN
        ,
        .perf_reqs      (perf_reqs),
        .perf_splits    (perf_splits),
        .perf_stalls    (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Bench-side region model.
    function automatic int regionOf(input logic [ADDR_WIDTH-1:0] a);
        return ((a & R0_MASK) == R0_BASE) ? 0 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $error("[TB] FAIL %s observed=timeout expected=completion", name);
    endtask

    // Drive a request and queue the sub-requests it should split into, lowest region first.
    task automatic applyStimulus(input logic [NUM_LANES-1:0] mask,
                                 input logic [ADDR_WIDTH-1:0] a0, input logic [ADDR_WIDTH-1:0] a1,
                                 input logic [ADDR_WIDTH-1:0] a2, input logic [ADDR_WIDTH-1:0] a3,
                                 input logic [TAG_WIDTH-1:0] tag);
        logic [ADDR_WIDTH-1:0] lane_addr [NUM_LANES];
        req_exp_t e;
        lane_addr[0] = a0;
        lane_addr[1] = a1;
        lane_addr[2] = a2;
        lane_addr[3] = a3;
        for (int l = 0; l < NUM_LANES; l++) in_req_addr[l*ADDR_WIDTH +: ADDR_WIDTH] = lane_addr[l];
        in_req_mask  = mask;
        in_req_tag   = tag;
        in_req_data  = {$urandom, $urandom, $urandom, $urandom};
        in_req_valid = 1'b1;
        for (int p = 0; p < NUM_OUTS; p++) begin
            e.port = p;
            e.mask = '0;
            e.tag  = tag;
            e.data = in_req_data;
            for (int l = 0; l < NUM_LANES; l++)
                if (mask[l] && regionOf(lane_addr[l]) == p) e.mask[l] = 1'b1;
            if (e.mask != '0) req_q.push_back(e);
        end
    endtask

    // Compare the current cycle's request-side outputs against the scoreboard head.
    task automatic checkReqBeat(input string name, output bit done);
        req_exp_t e;
        done = 1'b0;
        if (req_q.size() == 0) begin
            reportTimeout({name, "_no_expectation"});
            done = 1'b1;
            return;
        end
        e = req_q.pop_front();
        checkOutput({name, "_valid"}, DATA_W'(out_req_valid[e.port]), DATA_W'(1));
        checkOutput({name, "_other_valid"}, DATA_W'(out_req_valid[1 - e.port]), DATA_W'(0));
        checkOutput({name, "_mask"}, DATA_W'(out_req_mask[e.port]), DATA_W'(e.mask));
        checkOutput({name, "_tag"}, DATA_W'(out_req_tag[e.port]), DATA_W'(e.tag));
        checkOutput({name, "_data"}, out_req_data[e.port], e.data);
        checkOutput({name, "_in_ready"}, DATA_W'(in_req_ready), DATA_W'(req_q.size() == 0));
        done = (req_q.size() == 0);
    endtask

    // Walk the queued sub-requests one per cycle, then drop the request.
    task automatic runRequest(input string name);
        bit done;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            checkReqBeat(name, done);
            tick();
            if (done) begin
                in_req_valid = 1'b0;
                return;
            end
        end
        in_req_valid = 1'b0;
        reportTimeout(name);
    endtask

    // Compare the registered response port against the response scoreboard head.
    task automatic checkRsp(input string name);
        rsp_exp_t r;
        if (rsp_q.size() == 0) begin
            reportTimeout({name, "_no_expectation"});
            return;
        end
        r = rsp_q.pop_front();
        checkOutput({name, "_rsp_valid"}, DATA_W'(in_rsp_valid), DATA_W'(1));
        checkOutput({name, "_rsp_tag"}, DATA_W'(in_rsp_tag), DATA_W'(r.tag));
        checkOutput({name, "_rsp_mask"}, DATA_W'(in_rsp_mask), DATA_W'(r.mask));
        checkOutput({name, "_rsp_data"}, in_rsp_data, r.data);
    endtask

    initial begin
        int idx [NUM_OUTS];
        int w;
        rsp_exp_t r;

        for (int o = 0; o < NUM_OUTS; o++) begin
            out_req_ready[o] = 1'b1;
            out_rsp_valid[o] = 1'b0;
            out_rsp_mask[o]  = '0;
            out_rsp_data[o]  = '0;
            out_rsp_tag[o]   = '0;
        end

        // Reset values.
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_req_ready", DATA_W'(in_req_ready), DATA_W'(0));
        checkOutput("reset_out0_valid", DATA_W'(out_req_valid[0]), DATA_W'(0));
        checkOutput("reset_out1_valid", DATA_W'(out_req_valid[1]), DATA_W'(0));
        checkOutput("reset_in_rsp_valid", DATA_W'(in_rsp_valid), DATA_W'(0));
        checkOutput("reset_out_rsp_ready", DATA_W'({out_rsp_ready[1], out_rsp_ready[0]}), DATA_W'(0));
        tick();

        // Single-region request: same-cycle issue and acceptance.
        $display("[TB] single region request");
        applyStimulus(4'b1111, 30'h1000, 30'h1001, 30'h1002, 30'h1003, 8'h01);
        runRequest("single");

        // Two-region split: out0 then out1.
        $display("[TB] split request");
        applyStimulus(4'b1111, 30'h1000, 30'h2000, 30'h1004, 30'h2004, 8'h02);
        runRequest("split");

        // Reset while the second half of a split is stalled on out1.
        $display("[TB] reset mid-split");
        out_req_ready[1] = 1'b0;
        applyStimulus(4'b1111, 30'h1000, 30'h2000, 30'h1004, 30'h2004, 8'h03);
        @(negedge clk);
        checkOutput("midsplit_first_mask", DATA_W'(out_req_mask[0]), DATA_W'(4'b0101));
        checkOutput("midsplit_first_valid", DATA_W'(out_req_valid[0]), DATA_W'(1));
        tick();
        @(negedge clk);
        checkOutput("midsplit_second_valid", DATA_W'(out_req_valid[1]), DATA_W'(1));
        checkOutput("midsplit_second_mask", DATA_W'(out_req_mask[1]), DATA_W'(4'b1010));
        checkOutput("midsplit_in_ready", DATA_W'(in_req_ready), DATA_W'(0));
        tick();
        reset            = 1'b1;
        in_req_valid     = 1'b0;
        out_req_ready[1] = 1'b1;
        req_q.delete();
        model_rr = 0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postreset_out0_valid", DATA_W'(out_req_valid[0]), DATA_W'(0));
        checkOutput("postreset_out1_valid", DATA_W'(out_req_valid[1]), DATA_W'(0));
        checkOutput("postreset_in_ready", DATA_W'(in_req_ready), DATA_W'(0));
        checkOutput("postreset_rsp_valid", DATA_W'(in_rsp_valid), DATA_W'(0));
        tick();
        applyStimulus(4'b1111, 30'h1010, 30'h1011, 30'h1012, 30'h1013, 8'h04);
        runRequest("fresh_after_reset");

        // Pending limit: region0 already holds one; three more fill it, the fifth stalls.
        $display("[TB] pending limit");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 30'h1020, 30'h0, 30'h0, 30'h0, TAG_WIDTH'(8'h40 + i));
            runRequest("fill");
        end
        applyStimulus(4'b0001, 30'h1030, 30'h0, 30'h0, 30'h0, 8'h50);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("full_out0_valid", DATA_W'(out_req_valid[0]), DATA_W'(0));
            checkOutput("full_in_ready", DATA_W'(in_req_ready), DATA_W'(0));
            tick();
        end
        out_rsp_valid[0] = 1'b1;
        out_rsp_tag[0]   = 8'hA0;
        out_rsp_mask[0]  = 4'b0001;
        out_rsp_data[0]  = {4{32'hCAFE_0000}};
        r.tag  = 8'hA0;
        r.mask = 4'b0001;
        r.data = {4{32'hCAFE_0000}};
        rsp_q.push_back(r);
        @(negedge clk);
        checkOutput("full_rsp_ready", DATA_W'(out_rsp_ready[0]), DATA_W'(1));
        checkOutput("full_still_stalled", DATA_W'(out_req_valid[0]), DATA_W'(0));
        tick();
        out_rsp_valid[0] = 1'b0;
        model_rr = 1;
        @(negedge clk);
        checkRsp("full_release");
        begin
            bit done;
            checkReqBeat("released", done);
            checkOutput("released_done", DATA_W'(done), DATA_W'(1));
        end
        tick();
        in_req_valid = 1'b0;

        // Four global requests so out1 also has responses owed.
        $display("[TB] round-robin responses");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001, 30'h2000, 30'h0, 30'h0, 30'h0, TAG_WIDTH'(8'h60 + i));
            runRequest("global_fill");
        end

        // Both outputs return four responses back to back; merged stream alternates.
        idx[0] = 0;
        idx[1] = 0;
        for (int o = 0; o < NUM_OUTS; o++) begin
            out_rsp_valid[o] = 1'b1;
            out_rsp_mask[o]  = 4'b0001;
            out_rsp_tag[o]   = TAG_WIDTH'(8'h10 * (o + 1));
            out_rsp_data[o]  = DATA_W'(128'h100 * (o + 1));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            w = out_rsp_valid[model_rr] ? model_rr : 1 - model_rr;
            checkOutput("rr_grant", DATA_W'(out_rsp_ready[w]), DATA_W'(1));
            checkOutput("rr_other", DATA_W'(out_rsp_ready[1 - w]), DATA_W'(0));
            if (k > 0) checkRsp("rr_stream");
            r.tag  = TAG_WIDTH'(8'h10 * (w + 1) + idx[w]);
            r.mask = 4'b0001;
            r.data = DATA_W'(128'h100 * (w + 1) + idx[w]);
            rsp_q.push_back(r);
            tick();
            idx[w]++;
            model_rr = 1 - w;
            if (idx[w] == 4) begin
                out_rsp_valid[w] = 1'b0;
            end else begin
                out_rsp_tag[w]  = TAG_WIDTH'(8'h10 * (w + 1) + idx[w]);
                out_rsp_data[w] = DATA_W'(128'h100 * (w + 1) + idx[w]);
            end
        end
        out_rsp_valid[0] = 1'b0;
        out_rsp_valid[1] = 1'b0;
        @(negedge clk);
        checkRsp("rr_last");
        tick();
        @(negedge clk);
        checkOutput("rr_drained", DATA_W'(in_rsp_valid), DATA_W'(0));
        tick();

`ifdef MEM_SWITCH_PERF_EN
        // Counters after three split requests.
        $display("[TB] perf counters");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("perf_reset_splits", DATA_W'(perf_splits), DATA_W'(0));
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 30'h1000, 30'h2000, 30'h1004, 30'h2004, TAG_WIDTH'(8'h70 + i));
            runRequest("perf_split");
        end
        @(negedge clk);
        checkOutput("perf_splits", DATA_W'(perf_splits), DATA_W'(3));
        checkOutput("perf_reqs0", DATA_W'(perf_reqs[0]), DATA_W'(3));
        checkOutput("perf_reqs1", DATA_W'(perf_reqs[1]), DATA_W'(3));
        checkOutput("perf_stalls", DATA_W'(perf_stalls), DATA_W'(0));
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
